dft_axil_regs: RTL and testbench

Parametrised AXI4-Lite slave register file that replaces the fixed register front-end of the DFT accelerator. It decodes a configurable number of read/write control registers and read-only status registers. It accepts write address and write data in either order, and supports byte strobes, SLVERR on unmapped addresses, per-register write pulses and a masked, sticky interrupt controller with write-1-to-clear status. It sits between the PS AXI GP port and the DFT datapath/DMA control logic.

---
 rtl/dft_axil_regs.sv | 146 ++++++++++++++
 tb/tb_dft_axil_regs.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dft_axil_regs.sv
// dft_axil_regs: AXI4-Lite slave register file with RW control, RO status and a sticky W1C interrupt block.
module dft_axil_regs #(
    parameter int          ADDR_WIDTH = 24,
    parameter int          NUM_CTRL   = 8,
    parameter int          NUM_STAT   = 4,
    parameter int          NUM_IRQ    = 4,
    parameter logic [31:0] ID_VALUE   = 32'hDF7_0002,
    localparam int         SW         = (NUM_STAT > 0) ? 32 * NUM_STAT : 32
) (
    input  logic                     AXI_S_ACLK,
    input  logic                     AXI_S_ARESETn,
    input  logic                     AXI_S_AWVALID,
    output logic                     AXI_S_AWREADY,
    input  logic [ADDR_WIDTH-1:0]    AXI_S_AWADDR,
    input  logic [2:0]               AXI_S_AWPROT,
    input  logic                     AXI_S_WVALID,
    output logic                     AXI_S_WREADY,
    input  logic [31:0]              AXI_S_WDATA,
    input  logic [3:0]               AXI_S_WSTRB,
    output logic                     AXI_S_BVALID,
    input  logic                     AXI_S_BREADY,
    output logic [1:0]               AXI_S_BRESP,
    input  logic                     AXI_S_ARVALID,
    output logic                     AXI_S_ARREADY,
    input  logic [ADDR_WIDTH-1:0]    AXI_S_ARADDR,
    input  logic [2:0]               AXI_S_ARPROT,
    output logic                     AXI_S_RVALID,
    input  logic                     AXI_S_RREADY,
    output logic [31:0]              AXI_S_RDATA,
    output logic [1:0]               AXI_S_RRESP,
    output logic [32*NUM_CTRL-1:0]   CTRL_REGS,
    output logic [NUM_CTRL-1:0]      CTRL_WR,
    input  logic [SW-1:0]            STAT_REGS,
    input  logic [NUM_IRQ-1:0]       IRQ_IN,
    output logic                     INTERRUPT
);
    localparam int IW = ADDR_WIDTH - 2;
    localparam int STAT_BASE = 4 + NUM_CTRL;
    localparam int MAP_END = STAT_BASE + NUM_STAT;
    localparam logic [1:0] S_IDLE = 2'd0, S_HAVE_AW = 2'd1, S_HAVE_W = 2'd2, S_RESP = 2'd3;

    logic [1:0]         state_q, state_d;
    logic               init_q;
    logic [IW-1:0]      aw_idx_q;
    logic [31:0]        w_data_q;
    logic [3:0]         w_strb_q;
    logic [1:0]         bresp_q;
    logic               rvalid_q;
    logic [31:0]        rdata_q;
    logic [1:0]         rresp_q;
    logic [31:0]        ctrl_q [NUM_CTRL];
    logic [NUM_CTRL-1:0] ctrl_wr_q, ctrl_hit;
    logic [NUM_IRQ-1:0] irq_stat_q, irq_stat_d, irq_mask_q, irq_clr;
    logic               int_q;
    logic               aw_hs, w_hs, ar_hs, commit, rd_err;
    logic [IW-1:0]      wr_idx, rd_idx;
    logic [31:0]        wr_data, wr_mask, wr_bits, rd_data;
    logic [3:0]         wr_strb;
    logic               unused_ok;

    // init_q holds the readies low until the first edge after reset release
    assign AXI_S_AWREADY = init_q & (state_q == S_IDLE | state_q == S_HAVE_W);
    assign AXI_S_WREADY  = init_q & (state_q == S_IDLE | state_q == S_HAVE_AW);
    assign AXI_S_BVALID  = state_q == S_RESP;
    assign AXI_S_BRESP   = bresp_q;
    assign AXI_S_ARREADY = init_q & ~rvalid_q;
    assign AXI_S_RVALID  = rvalid_q;
    assign AXI_S_RDATA   = rdata_q;
    assign AXI_S_RRESP   = rresp_q;
    assign CTRL_WR       = ctrl_wr_q;
    assign INTERRUPT     = int_q;
    assign unused_ok     = ^{AXI_S_AWPROT, AXI_S_ARPROT, AXI_S_AWADDR[1:0], AXI_S_ARADDR[1:0]};

    assign aw_hs   = AXI_S_AWVALID & AXI_S_AWREADY;
    assign w_hs    = AXI_S_WVALID & AXI_S_WREADY;
    assign ar_hs   = AXI_S_ARVALID & AXI_S_ARREADY;
    assign commit  = (aw_hs | state_q == S_HAVE_AW) & (w_hs | state_q == S_HAVE_W);
    assign wr_idx  = (state_q == S_HAVE_AW) ? aw_idx_q : AXI_S_AWADDR[ADDR_WIDTH-1:2];
    assign wr_data = (state_q == S_HAVE_W) ? w_data_q : AXI_S_WDATA;
    assign wr_strb = (state_q == S_HAVE_W) ? w_strb_q : AXI_S_WSTRB;
    assign wr_mask = {{8{wr_strb[3]}}, {8{wr_strb[2]}}, {8{wr_strb[1]}}, {8{wr_strb[0]}}};
    assign wr_bits = wr_data & wr_mask;
    assign rd_idx  = AXI_S_ARADDR[ADDR_WIDTH-1:2];
    assign rd_err  = rd_idx >= IW'(MAP_END);

    assign state_d = commit ? S_RESP :
                     aw_hs ? S_HAVE_AW :
                     w_hs ? S_HAVE_W :
                     (AXI_S_BVALID & AXI_S_BREADY) ? S_IDLE : state_q;

    // set beats clear when IRQ_IN and a W1C land on the same edge
    assign irq_clr    = (commit && wr_idx == IW'(1)) ? wr_bits[NUM_IRQ-1:0] : '0;
    assign irq_stat_d = (irq_stat_q & ~irq_clr) | IRQ_IN;

    for (genvar i = 0; i < NUM_CTRL; i++) begin : g_ctrl
        assign CTRL_REGS[32*i +: 32] = ctrl_q[i];
        assign ctrl_hit[i] = commit && wr_idx == IW'(4 + i);
    end

    always_comb begin
        rd_data = '0;
        if (rd_idx == IW'(0)) rd_data = ID_VALUE;
        if (rd_idx == IW'(1)) rd_data = 32'(irq_stat_q);
        if (rd_idx == IW'(2)) rd_data = 32'(irq_mask_q);
        for (int i = 0; i < NUM_CTRL; i++)
            if (rd_idx == IW'(4 + i)) rd_data = ctrl_q[i];
        for (int i = 0; i < NUM_STAT; i++)
            if (rd_idx == IW'(STAT_BASE + i)) rd_data = STAT_REGS[32*i +: 32];
    end

    always_ff @(posedge AXI_S_ACLK or negedge AXI_S_ARESETn) begin
        if (!AXI_S_ARESETn) begin
            state_q    <= S_IDLE;
            init_q     <= 1'b0;
            aw_idx_q   <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bresp_q    <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            ctrl_wr_q  <= '0;
            irq_stat_q <= '0;
            irq_mask_q <= '0;
            int_q      <= 1'b0;
            for (int i = 0; i < NUM_CTRL; i++) ctrl_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            init_q     <= 1'b1;
            aw_idx_q   <= aw_hs ? AXI_S_AWADDR[ADDR_WIDTH-1:2] : aw_idx_q;
            w_data_q   <= w_hs ? AXI_S_WDATA : w_data_q;
            w_strb_q   <= w_hs ? AXI_S_WSTRB : w_strb_q;
            bresp_q    <= commit ? (wr_idx >= IW'(MAP_END) ? 2'b10 : 2'b00) : bresp_q;
            rvalid_q   <= ar_hs | (rvalid_q & ~AXI_S_RREADY);
            rdata_q    <= ar_hs ? rd_data : rdata_q;
            rresp_q    <= ar_hs ? (rd_err ? 2'b10 : 2'b00) : rresp_q;
            ctrl_wr_q  <= ctrl_hit;
            irq_stat_q <= irq_stat_d;
            int_q      <= |(irq_stat_q & irq_mask_q);
            if (commit && wr_idx == IW'(2))
                irq_mask_q <= (irq_mask_q & ~wr_mask[NUM_IRQ-1:0]) | wr_bits[NUM_IRQ-1:0];
            for (int i = 0; i < NUM_CTRL; i++)
                if (ctrl_hit[i]) ctrl_q[i] <= (ctrl_q[i] & ~wr_mask) | wr_bits;
        end
    end
endmodule

// File: tb/tb_dft_axil_regs.sv
// tb_dft_axil_regs: scoreboard bench for dft_axil_regs; expected B/R responses are queued at issue and popped at handshake.
module tb_dft_axil_regs;
    localparam int AW = 24, NC = 8, NS = 4, NI = 4;
    localparam logic [31:0] ID = 32'hDF7_0002;

    logic clk, rst_n;
    logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready, interrupt;
    logic [AW-1:0] awaddr, araddr;
    logic [31:0] wdata, rdata;
    logic [3:0] wstrb;
    logic [1:0] bresp, rresp;
    logic [32*NC-1:0] ctrl_regs, snap;
    logic [NC-1:0] ctrl_wr;
    logic [32*NS-1:0] stat_regs;
    logic [NI-1:0] irq_in;

    int checks = 0, failures = 0, b_cnt = 0, wr0_cnt = 0;
    logic [33:0] rq[$];
    logic [1:0]  bq[$];

    dft_axil_regs dut (
        .AXI_S_ACLK(clk), .AXI_S_ARESETn(rst_n),
        .AXI_S_AWVALID(awvalid), .AXI_S_AWREADY(awready), .AXI_S_AWADDR(awaddr), .AXI_S_AWPROT(3'b000),
        .AXI_S_WVALID(wvalid), .AXI_S_WREADY(wready), .AXI_S_WDATA(wdata), .AXI_S_WSTRB(wstrb),
        .AXI_S_BVALID(bvalid), .AXI_S_BREADY(bready), .AXI_S_BRESP(bresp),
        .AXI_S_ARVALID(arvalid), .AXI_S_ARREADY(arready), .AXI_S_ARADDR(araddr), .AXI_S_ARPROT(3'b000),
        .AXI_S_RVALID(rvalid), .AXI_S_RREADY(rready), .AXI_S_RDATA(rdata), .AXI_S_RRESP(rresp),
        .CTRL_REGS(ctrl_regs), .CTRL_WR(ctrl_wr), .STAT_REGS(stat_regs),
        .IRQ_IN(irq_in), .INTERRUPT(interrupt)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    assign stat_regs = {32'h5555_0003, 32'h5555_0002, 32'h5555_0001, 32'h5555_0000};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bvalid && bready) begin
                b_cnt++;
                if (bq.size() == 0) check("b_unexpected", 1, 0);
                else check("bresp", 64'(bresp), 64'(bq.pop_front()));
            end
            if (rvalid && rready) begin
                if (rq.size() == 0) check("r_unexpected", 1, 0);
                else check("rdata_rresp", 64'({rdata, rresp}), 64'(rq.pop_front()));
            end
            if (ctrl_wr[0]) wr0_cnt++;
        end
    end

    task automatic do_aw(input int idx);
        int n = 0;
        logic hs = 0;
        @(posedge clk); #1;
        awvalid = 1; awaddr = AW'(idx * 4);
        do begin @(negedge clk); hs = awready; @(posedge clk); n++; end while (!hs && n < 50);
        #1 awvalid = 0;
        if (!hs) check("aw_timeout", 0, 1);
    endtask

    task automatic do_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        logic hs = 0;
        @(posedge clk); #1;
        wvalid = 1; wdata = d; wstrb = s;
        do begin @(negedge clk); hs = wready; @(posedge clk); n++; end while (!hs && n < 50);
        #1 wvalid = 0;
        if (!hs) check("w_timeout", 0, 1);
    endtask

    task automatic write(input int idx, input logic [31:0] d, input logic [3:0] s,
                         input int aw_dly, input int w_dly, input logic [1:0] exp);
        bq.push_back(exp);
        fork
            begin repeat (aw_dly) @(posedge clk); do_aw(idx); end
            begin repeat (w_dly) @(posedge clk); do_w(d, s); end
        join
    endtask

    task automatic wait_b();
        int n = 0;
        logic hs = 0;
        do begin @(negedge clk); hs = bvalid && bready; @(posedge clk); n++; end while (!hs && n < 100);
        if (!hs) check("b_timeout", 0, 1);
        #1;
    endtask

    task automatic read(input int idx, input logic [31:0] d, input logic [1:0] r);
        int n = 0;
        logic hs = 0;
        rq.push_back({d, r});
        @(posedge clk); #1;
        arvalid = 1; araddr = AW'(idx * 4);
        do begin @(negedge clk); hs = arready; @(posedge clk); n++; end while (!hs && n < 50);
        #1 arvalid = 0;
        if (!hs) check("ar_timeout", 0, 1);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst_n = 0; awvalid = 1; wvalid = 1; arvalid = 1; bready = 1; rready = 1;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0; irq_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_readies", 64'({awready, wready, arready}), 0);
        check("rst_valids", 64'({bvalid, rvalid, interrupt, ctrl_wr}), 0);
        check("rst_ctrl0", 64'(ctrl_regs[31:0]), 0);
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; arvalid = 0; rst_n = 1;
        @(negedge clk);
        check("ready_pre_edge", 64'(awready), 0);
        @(negedge clk);
        check("ready_post_edge", 64'({awready, wready, arready}), 64'h7);
        read(0, ID, 2'b00);

        wr0_cnt = 0; b_cnt = 0;
        write(4, 32'hA5A5_A5A5, 4'b0101, 2, 0, 2'b00);
        wait_b();
        repeat (3) @(posedge clk);
        check("w_first_ctrl0", 64'(ctrl_regs[31:0]), 64'h00A5_00A5);
        check("ctrl_wr0_pulses", 64'(wr0_cnt), 1);
        check("single_bvalid", 64'(b_cnt), 1);

        bready = 0;
        write(5, 32'h1234_5678, 4'hF, 0, 0, 2'b00);
        for (int i = 0; i < 20 && !bvalid; i++) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_bvalid_bresp", 64'({bvalid, bresp}), 64'h4);
            check("bp_readies", 64'({awready, wready}), 0);
        end
        @(posedge clk); #1 bready = 1;
        wait_b();
        @(negedge clk);
        check("bp_ready_back", 64'({awready, wready}), 64'h3);
        check("ctrl1", 64'(ctrl_regs[63:32]), 64'h1234_5678);
        read(5, 32'h1234_5678, 2'b00);

        snap = ctrl_regs;
        write(4 + NC + NS, 32'hFFFF_FFFF, 4'hF, 0, 0, 2'b10);
        wait_b();
        check("unmapped_noop", 64'(ctrl_regs == snap), 1);
        read(4 + NC + NS, 32'h0, 2'b10);
        read(4 + NC, 32'h5555_0000, 2'b00);
        read(3, 32'h0, 2'b00);

        write(2, 32'h2, 4'hF, 0, 0, 2'b00);
        wait_b();
        @(posedge clk); #1 irq_in = 4'b0010;
        @(posedge clk); #1 irq_in = 4'b0000;
        @(negedge clk);
        check("irq_not_yet", 64'(interrupt), 0);
        @(negedge clk);
        check("irq_assert", 64'(interrupt), 1);

        bq.push_back(2'b00);
        @(posedge clk); #1;
        awvalid = 1; awaddr = AW'(4); wvalid = 1; wdata = 32'h2; wstrb = 4'hF; irq_in = 4'b0010;
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; irq_in = 4'b0000;
        wait_b();
        read(1, 32'h2, 2'b00);
        check("irq_set_wins", 64'(interrupt), 1);

        bq.push_back(2'b00);
        @(posedge clk); #1;
        awvalid = 1; awaddr = AW'(4); wvalid = 1; wdata = 32'h2; wstrb = 4'hF;
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        @(negedge clk);
        check("irq_hold", 64'(interrupt), 1);
        @(negedge clk);
        check("irq_clear", 64'(interrupt), 0);
        repeat (2) @(posedge clk);
        read(1, 32'h0, 2'b00);

        write(4, 32'h11, 4'hF, 0, 0, 2'b00);
        wait_b();
        rq.push_back({32'h11, 2'b00});
        bq.push_back(2'b00);
        @(posedge clk); #1;
        awvalid = 1; awaddr = AW'(16); wvalid = 1; wdata = 32'h22; wstrb = 4'hF;
        arvalid = 1; araddr = AW'(16);
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; arvalid = 0;
        repeat (3) @(posedge clk);
        read(4, 32'h22, 2'b00);

        repeat (3) @(posedge clk);
        check("bq_drained", 64'(bq.size()), 0);
        check("rq_drained", 64'(rq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
